// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with registered result and persistent z/c/n/v flags.
// One operation is accepted per valid/ready handshake. Add/sub/logic/compare
// finish on the accepting edge; shifts and popcount step once per clock.
module alu_seq #(
  parameter  int W  = 8,
  localparam int CW = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         optype,
  input  logic [3:0]   op,
  input  logic [W-1:0] acc_in,
  input  logic [W-1:0] reg_in,
  output logic         out_valid,
  output logic [W-1:0] result,
  output logic         z,
  output logic         c,
  output logic         n,
  output logic         v,
  output logic         busy,
  output logic         illegal
);

  // FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ITER = 1'b1;

  // Opcodes understood when optype is 0
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_SUB    = 4'b0011;
  localparam logic [3:0] OP_SHL    = 4'b0100;
  localparam logic [3:0] OP_SHR    = 4'b0101;
  localparam logic [3:0] OP_AND    = 4'b0110;
  localparam logic [3:0] OP_OR     = 4'b0111;
  localparam logic [3:0] OP_XOR    = 4'b1000;
  localparam logic [3:0] OP_POPCNT = 4'b1001;
  localparam logic [3:0] OP_CMP    = 4'b1010;

  // Iteration count for a full-width shift or a popcount, and W widened so it
  // can be compared against an operand without truncation.
  localparam logic [CW-1:0] W_CNT = CW'(W);
  localparam logic [W:0]    W_EXT = (W + 1)'(W);

  // State and working registers
  logic [0:0]    state;
  logic [3:0]    op_q;
  logic [W-1:0]  work;
  logic [CW-1:0] pop_cnt;
  logic [CW-1:0] cnt;

  // Next-state values
  logic [0:0]    state_d;
  logic [3:0]    op_d;
  logic [W-1:0]  work_d;
  logic [CW-1:0] pop_d;
  logic [CW-1:0] cnt_d;
  logic [W-1:0]  result_d;
  logic          z_d, c_d, n_d, v_d;
  logic          out_valid_d, illegal_d;
  logic          set_zn;

  // Datapath intermediates
  logic [W:0]    sum;
  logic [W-1:0]  diff;
  logic [CW-1:0] shift_n;
  logic [W-1:0]  step_work;
  logic          step_carry;
  logic [CW-1:0] step_pop;

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state == ST_ITER);

  // Shift distance saturates at W: anything longer clears the operand anyway
  always_comb begin
    if ({1'b0, reg_in} >= W_EXT) shift_n = W_CNT;
    else                         shift_n = reg_in[CW-1:0];
  end

  // Single-cycle arithmetic on the presented operands
  always_comb begin
    sum  = {1'b0, acc_in} + {1'b0, reg_in};
    diff = acc_in - reg_in;
  end

  // One iteration step of the op currently held in op_q
  always_comb begin
    step_work  = work;
    step_carry = 1'b0;
    step_pop   = pop_cnt;
    case (op_q)
      OP_SHL: begin
        step_work  = {work[W-2:0], 1'b0};
        step_carry = work[W-1];
      end
      OP_SHR: begin
        step_work  = {1'b0, work[W-1:1]};
        step_carry = work[0];
      end
      default: begin
        step_work = work >> 1;
        step_pop  = pop_cnt + CW'(work[0]);
      end
    endcase
  end

  // Next-state logic: accept in IDLE, step in ITER, flags only move on completion
  always_comb begin
    state_d     = state;
    op_d        = op_q;
    work_d      = work;
    pop_d       = pop_cnt;
    cnt_d       = cnt;
    result_d    = result;
    z_d         = z;
    c_d         = c;
    n_d         = n;
    v_d         = v;
    out_valid_d = 1'b0;
    illegal_d   = 1'b0;
    set_zn      = 1'b0;

    if (state == ST_IDLE) begin
      if (in_valid) begin
        op_d = op;
        if (optype) begin
          out_valid_d = 1'b1;
          illegal_d   = 1'b1;
        end else begin
          case (op)
            OP_ADD: begin
              result_d    = sum[W-1:0];
              c_d         = sum[W];
              v_d         = (acc_in[W-1] == reg_in[W-1]) && (sum[W-1] != acc_in[W-1]);
              set_zn      = 1'b1;
              out_valid_d = 1'b1;
            end
            OP_SUB: begin
              result_d    = diff;
              c_d         = (acc_in < reg_in);
              v_d         = (acc_in[W-1] != reg_in[W-1]) && (diff[W-1] != acc_in[W-1]);
              set_zn      = 1'b1;
              out_valid_d = 1'b1;
            end
            OP_AND: begin
              result_d    = acc_in & reg_in;
              set_zn      = 1'b1;
              out_valid_d = 1'b1;
            end
            OP_OR: begin
              result_d    = acc_in | reg_in;
              set_zn      = 1'b1;
              out_valid_d = 1'b1;
            end
            OP_XOR: begin
              result_d    = acc_in ^ reg_in;
              set_zn      = 1'b1;
              out_valid_d = 1'b1;
            end
            OP_CMP: begin
              z_d         = (acc_in == reg_in);
              n_d         = (acc_in < reg_in);
              out_valid_d = 1'b1;
            end
            OP_SHL, OP_SHR: begin
              if (shift_n == '0) begin
                result_d    = acc_in;
                c_d         = 1'b0;
                set_zn      = 1'b1;
                out_valid_d = 1'b1;
              end else begin
                work_d  = acc_in;
                cnt_d   = shift_n;
                state_d = ST_ITER;
              end
            end
            OP_POPCNT: begin
              work_d  = reg_in;
              pop_d   = '0;
              cnt_d   = W_CNT;
              state_d = ST_ITER;
            end
            default: begin
              out_valid_d = 1'b1;
              illegal_d   = 1'b1;
            end
          endcase
        end
      end
    end else begin
      work_d = step_work;
      pop_d  = step_pop;
      cnt_d  = cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b1;
        set_zn      = 1'b1;
        if (op_q == OP_POPCNT) begin
          result_d = W'(step_pop);
        end else begin
          result_d = step_work;
          c_d      = step_carry;
        end
      end
    end

    if (set_zn) begin
      z_d = (result_d == '0);
      n_d = result_d[W-1];
    end
  end

  // State, operand and output registers; reset abandons any op in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      work      <= '0;
      pop_cnt   <= '0;
      cnt       <= '0;
      result    <= '0;
      z         <= 1'b0;
      c         <= 1'b0;
      n         <= 1'b0;
      v         <= 1'b0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state     <= state_d;
      op_q      <= op_d;
      work      <= work_d;
      pop_cnt   <= pop_d;
      cnt       <= cnt_d;
      result    <= result_d;
      z         <= z_d;
      c         <= c_d;
      n         <= n_d;
      v         <= v_d;
      out_valid <= out_valid_d;
      illegal   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq with a queue-based scoreboard.
// Stimulus pushes the hand-computed response and its expected completion
// cycle; a monitor pops and compares on every out_valid pulse.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         optype;
  logic [3:0]   op;
  logic [W-1:0] acc_in;
  logic [W-1:0] reg_in;
  logic         out_valid;
  logic [W-1:0] result;
  logic         z, c, n, v;
  logic         busy;
  logic         illegal;

  typedef struct {
    logic [W-1:0] res;
    logic         z, c, n, v, ill;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0011, SHL = 4'b0100, SHR = 4'b0101;
  localparam logic [3:0] AND_ = 4'b0110, OR_ = 4'b0111, XOR_ = 4'b1000;
  localparam logic [3:0] POP = 4'b1001, CMP = 4'b1010;

  alu_seq #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .optype    (optype),
    .op        (op),
    .acc_in    (acc_in),
    .reg_in    (reg_in),
    .out_valid (out_valid),
    .result    (result),
    .z         (z),
    .c         (c),
    .n         (n),
    .v         (v),
    .busy      (busy),
    .illegal   (illegal)
  );

  // Free-running clock and edge counter used to check completion latency
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Drive one op once the DUT is ready and record what it must return
  task automatic applyStimulus(input logic ot, input logic [3:0] opc,
                               input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                               input logic [W-1:0] er, input logic ez, input logic ec,
                               input logic en, input logic ev, input logic eil);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    optype   = ot;
    op       = opc;
    acc_in   = a;
    reg_in   = b;
    e.res = er; e.z = ez; e.c = ec; e.n = en; e.v = ev; e.ill = eil;
    e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic dropValid();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("result",   32'(result),  32'(mon_e.res));
        checkOutput("z",        32'(z),       32'(mon_e.z));
        checkOutput("c",        32'(c),       32'(mon_e.c));
        checkOutput("n",        32'(n),       32'(mon_e.n));
        checkOutput("v",        32'(v),       32'(mon_e.v));
        checkOutput("illegal",  32'(illegal), 32'(mon_e.ill));
        checkOutput("latency",  32'(cyc),     32'(mon_e.cyc));
      end
    end
  end

  // Directed sequence
  initial begin
    int waited;
    reset    = 1'b1;
    in_valid = 1'b0;
    optype   = 1'b0;
    op       = 4'b0000;
    acc_in   = '0;
    reg_in   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_result",    32'(result),    32'd0);
    checkOutput("rst_flags",     32'({z, c, n, v}), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    reset = 1'b0;

    //             ot    op    acc    reg    lat  res    z  c  n  v  ill
    applyStimulus(1'b0, ADD,  8'h7F, 8'h01, 0, 8'h80, 0, 0, 1, 1, 0);
    applyStimulus(1'b0, ADD,  8'hFF, 8'h01, 0, 8'h00, 1, 1, 0, 0, 0);
    applyStimulus(1'b0, SUB,  8'h05, 8'h07, 0, 8'hFE, 0, 1, 1, 0, 0);
    applyStimulus(1'b0, CMP,  8'h07, 8'h07, 0, 8'hFE, 1, 1, 0, 0, 0);
    applyStimulus(1'b0, AND_, 8'hF0, 8'h3C, 0, 8'h30, 0, 1, 0, 0, 0);
    applyStimulus(1'b0, XOR_, 8'hFF, 8'h0F, 0, 8'hF0, 0, 1, 1, 0, 0);
    applyStimulus(1'b0, OR_,  8'h00, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0);
    applyStimulus(1'b0, SUB,  8'h80, 8'h01, 0, 8'h7F, 0, 0, 0, 1, 0);
    applyStimulus(1'b0, SHL,  8'h81, 8'h03, 3, 8'h08, 0, 0, 0, 1, 0);
    applyStimulus(1'b0, SHR,  8'h81, 8'h00, 0, 8'h81, 0, 0, 1, 1, 0);
    applyStimulus(1'b0, SHR,  8'hB4, 8'h03, 3, 8'h16, 0, 1, 0, 1, 0);
    applyStimulus(1'b0, SHL,  8'h81, 8'hC8, 8, 8'h00, 1, 1, 0, 1, 0);

    // in_valid stays high through the iterations and must not be taken
    applyStimulus(1'b0, POP,  8'h12, 8'hFF, 8, 8'h08, 0, 1, 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checkOutput("iter_busy",     32'(busy),     32'd1);
      checkOutput("iter_in_ready", 32'(in_ready), 32'd0);
    end
    applyStimulus(1'b0, POP,  8'hFF, 8'h00, 8, 8'h00, 1, 1, 0, 1, 0);
    applyStimulus(1'b0, POP,  8'h00, 8'hA5, 8, 8'h04, 0, 1, 0, 1, 0);

    // Back-to-back single-cycle ops, then undefined encodings
    applyStimulus(1'b0, ADD,  8'h10, 8'h20, 0, 8'h30, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, ADD,  8'h70, 8'h10, 0, 8'h80, 0, 0, 1, 1, 0);
    applyStimulus(1'b1, ADD,  8'h01, 8'h01, 0, 8'h80, 0, 0, 1, 1, 1);
    applyStimulus(1'b0, 4'hF, 8'h00, 8'h00, 0, 8'h80, 0, 0, 1, 1, 1);

    // Reset in the middle of a popcount kills it without an out_valid
    applyStimulus(1'b0, POP,  8'h00, 8'hFF, 8, 8'h08, 0, 0, 0, 1, 0);
    dropValid();
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    if (sb.size() > 0) void'(sb.pop_back());
    #1;
    checkOutput("midrst_result",    32'(result),       32'd0);
    checkOutput("midrst_flags",     32'({z, c, n, v}), 32'd0);
    checkOutput("midrst_out_valid", 32'(out_valid),    32'd0);
    checkOutput("midrst_busy",      32'(busy),         32'd0);
    checkOutput("midrst_illegal",   32'(illegal),      32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    applyStimulus(1'b0, ADD,  8'h01, 8'h01, 0, 8'h02, 0, 0, 0, 0, 0);
    dropValid();

    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the datapath ALU.
- Accepts one operation per valid/ready handshake and returns a registered result with a one-cycle out_valid pulse.
- Keeps z/c/n/v in real flip-flops that persist across operations, replacing latched flags.
- Shifts and popcount run iteratively, one step per clock. Single-cycle ops complete in one clock. Sits between the accumulator/register file and the branch unit, which reads the flags.

Parameters:
- W, 8, operand/result width in bits (W >= 2).
- CW, $clog2(W+1), iteration-counter width (derived; not to be overridden).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high in IDLE
- optype  in  1  0 = ALU op; 1 = not an ALU op
- op  in  4  opcode, sampled on accept
- acc_in  in  W  first operand (accumulator)
- reg_in  in  W  second operand / shift amount
- out_valid  out  1  one-cycle pulse: result and flags are final
- result  out  W  registered result, held until the next completing op changes it
- z  out  1  zero flag (registered)
- c  out  1  carry/borrow flag (registered)
- n  out  1  negative / less-than flag (registered)
- v  out  1  signed overflow flag (registered)
- busy  out  1  high in ITER
- illegal  out  1  pulses with out_valid when the accepted op was undefined

Behaviour:
- Reset (async, any state): state = IDLE; result = 0; z = c = n = v = 0; out_valid = busy = illegal = 0; counter and operand registers = 0. An in-flight op is discarded with no out_valid.
- Accept: in_valid && in_ready at a rising edge. Operands and op are latched on that edge. in_ready = (state == IDLE), including the out_valid cycle, so back-to-back ops are allowed.
- States: IDLE, ITER. IDLE -> ITER on accept of an iterative op with N > 0. ITER -> IDLE on the edge that performs iteration N. ITER ignores in_valid.
- Latency: for single-cycle ops, accept at edge k gives out_valid high between edges k and k+1. For iterative ops, one step per edge k+1..k+N, then out_valid high after edge k+N.
- Single-cycle ops (optype = 0):
  - 0010 ADD: {c, result} = acc + reg, (W+1)-bit sum. v = signed overflow.
  - 0011 SUB: result = acc - reg. c = 1 iff borrow (acc < reg unsigned). v = signed overflow.
  - 0110 AND, 0111 OR, 1000 XOR: c and v unchanged.
  - 1010 CMP (unsigned): z = (acc == reg); n = (acc < reg). result, c and v unchanged.
- Iterative ops (optype = 0):
  - 0100 SHL, 0101 SHR: N = min(reg_in, W). One-bit logical shift per step. c = last bit shifted out; c = 0 when N = 0. N = 0 completes as a single-cycle op with result = acc. N >= W yields result 0. v unchanged.
  - 1001 POPCNT: counts set bits of reg_in (acc_in ignored). N = W, one bit examined per step, LSB first. Result is in 0..W and never exceeds W. c and v unchanged.
- Flags, all ops except CMP: z = (result == 0); n = result[W-1].
- Flag timing: flags update only on the edge that raises out_valid. Between ops they hold their values.
- Undefined op (optype = 1, or opcode not listed above): completes as a single-cycle op. result and flags unchanged; illegal = 1 with out_valid.

Test Plan:
- W = 8, ADD 0x7F + 0x01 -> out_valid 1 cycle after accept; result 0x80, c 0, v 1, n 1, z 0. Then ADD 0xFF + 0x01 -> result 0x00, c 1, z 1, v 0.
- SUB 0x05 - 0x07 -> result 0xFE, c 1, n 1. Follow with CMP 0x07 vs 0x07 -> z 1, n 0, result still 0xFE, c still 1.
- SHL acc 0x81 by 3 -> busy for 3 cycles, out_valid after edge k+3; result 0x08, c 0. SHR 0x81 by 0 -> 1-cycle latency, result 0x81, c 0. SHL by 200 -> 8 iterations, result 0x00, z 1.
- POPCNT reg 0xFF -> result 8 after 8 iterations. POPCNT 0x00 -> result 0, z 1. in_valid held high during ITER is not accepted; in_ready low and busy high throughout.
- Back-to-back: ADD accepted in the out_valid cycle of the previous op -> consecutive out_valid pulses with no bubble. optype = 1 -> illegal pulse, result and flags unchanged.
- Assert reset mid-POPCNT (iteration 4) -> all outputs 0 immediately (asynchronous); no out_valid. First op after reset release completes normally.
